// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock qualifier running on the raw oscillator clock: pulses the PLL
// reset, waits for a synchronised lock, qualifies it, then releases sys_rst.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             locked,
    input  logic             clr_counts,
    output logic             pll_resetb,
    output logic             sys_rst,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_count,
    output logic [CNT_W-1:0] retry_count
);

    // Timer is wide enough for the longest dwell of any state
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + STABLE_CYCLES + PLL_RST_CYCLES + 1);

    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_t                 state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pll_resetb_q, pll_resetb_d;
    logic                   sys_rst_q, sys_rst_d;
    logic                   ready_q, ready_d;
    logic [CNT_W-1:0]       loss_q, loss_d;
    logic [CNT_W-1:0]       retry_q, retry_d;
    logic                   locked_s;
    logic                   retry_inc;
    logic                   loss_inc;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], locked};
    end

    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        case (state_q)
            S_PLL_RST: begin
                if (timer_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (timer_q == TMO_LAST) begin
                    state_d   = S_PLL_RST;
                    retry_inc = 1'b1;
                end
            end
            S_STABLE: begin
                // A drop on the final qualifying cycle still falls back to WAIT_LOCK
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (timer_q == STB_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d  = S_PLL_RST;
                    loss_inc = 1'b1;
                end
            end
            default: state_d = S_PLL_RST;
        endcase
    end

    always_comb begin
        timer_d = (state_d != state_q) ? '0 : timer_q + TMR_ONE;
    end

    // Outputs decoded from the next state so they switch on the transition edge
    always_comb begin
        pll_resetb_d = (state_d != S_PLL_RST);
        sys_rst_d    = (state_d != S_RUN);
        ready_d      = (state_d == S_RUN);
    end

    always_comb begin
        retry_d = retry_q;
        loss_d  = loss_q;
        if (clr_counts) begin
            retry_d = '0;
            loss_d  = '0;
        end else begin
            if (retry_inc) retry_d = sat_inc(retry_q);
            if (loss_inc)  loss_d  = sat_inc(loss_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_PLL_RST;
            timer_q      <= '0;
            sync_q       <= '0;
            pll_resetb_q <= 1'b0;
            sys_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
            loss_q       <= '0;
            retry_q      <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            sync_q       <= sync_d;
            pll_resetb_q <= pll_resetb_d;
            sys_rst_q    <= sys_rst_d;
            ready_q      <= ready_d;
            loss_q       <= loss_d;
            retry_q      <= retry_d;
        end
    end

    assign pll_resetb      = pll_resetb_q;
    assign sys_rst         = sys_rst_q;
    assign ready           = ready_q;
    assign lock_loss_count = loss_q;
    assign retry_count     = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: phase/age reference model checked every cycle
// plus literal expectations on the directed scenarios.
module tb_pll_reset_sequencer;

    localparam int SS   = 2;
    localparam int PR   = 4;
    localparam int TO   = 32;
    localparam int ST   = 8;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          locked = 1'b0;
    logic          clr_counts = 1'b0;
    logic          pll_resetb;
    logic          sys_rst;
    logic          ready;
    logic [CW-1:0] lock_loss_count;
    logic [CW-1:0] retry_count;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .SYNC_STAGES   (SS),
        .PLL_RST_CYCLES(PR),
        .TIMEOUT_CYCLES(TO),
        .STABLE_CYCLES (ST),
        .CNT_W         (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .locked         (locked),
        .clr_counts     (clr_counts),
        .pll_resetb     (pll_resetb),
        .sys_rst        (sys_rst),
        .ready          (ready),
        .lock_loss_count(lock_loss_count),
        .retry_count    (retry_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = PLL reset pulse, 1 = waiting for lock,
    // 2 = qualifying lock, 3 = running. age = cycles already spent in phase.
    int m_phase = 0;
    int m_age   = 0;
    int m_rt    = 0;
    int m_ll    = 0;
    bit m_sh[SS];

    always @(posedge clk or negedge rst_n) begin : model
        int nxt;
        bit ls;
        bit rt_ev;
        bit ll_ev;
        if (!rst_n) begin
            m_phase = 0;
            m_age   = 0;
            m_rt    = 0;
            m_ll    = 0;
            for (int i = 0; i < SS; i++) m_sh[i] = 1'b0;
        end else begin
            ls    = m_sh[SS-1];
            nxt   = m_phase;
            rt_ev = 1'b0;
            ll_ev = 1'b0;
            if (m_phase == 0) begin
                if (m_age + 1 == PR) nxt = 1;
            end else if (m_phase == 1) begin
                if (ls) nxt = 2;
                else if (m_age + 1 == TO) begin
                    nxt   = 0;
                    rt_ev = 1'b1;
                end
            end else if (m_phase == 2) begin
                if (!ls) nxt = 1;
                else if (m_age + 1 == ST) nxt = 3;
            end else begin
                if (!ls) begin
                    nxt   = 0;
                    ll_ev = 1'b1;
                end
            end
            m_age   = (nxt == m_phase) ? m_age + 1 : 0;
            m_phase = nxt;
            for (int i = SS - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
            m_sh[0] = locked;
            if (clr_counts) begin
                m_rt = 0;
                m_ll = 0;
            end else begin
                if (rt_ev && m_rt < CMAX) m_rt++;
                if (ll_ev && m_ll < CMAX) m_ll++;
            end
        end
    end

    always @(negedge clk) begin
        chk("model pll_resetb", pll_resetb, m_phase != 0);
        chk("model sys_rst", sys_rst, m_phase != 3);
        chk("model ready", ready, m_phase == 3);
        chk("model retry_count", retry_count, m_rt);
        chk("model lock_loss_count", lock_loss_count, m_ll);
    end

    int ec;

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            ec++;
        end
    endtask

    task automatic upto(input int k);
        while (ec < k) step(1);
    endtask

    task automatic restart(input logic lk);
        #2 rst_n = 1'b0;
        clr_counts = 1'b0;
        locked     = lk;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ec    = 0;
    endtask

    initial begin
        rst_n = 1'b0;

        // Lock already present at release
        restart(1'b1);
        upto(3);  chk("s1 pll_resetb low e3", pll_resetb, 1'b0);
        upto(4);  chk("s1 pll_resetb high e4", pll_resetb, 1'b1);
                  chk("s1 sys_rst e4", sys_rst, 1'b1);
        upto(12); chk("s1 ready e12", ready, 1'b0);
        upto(13); chk("s1 ready e13", ready, 1'b1);
                  chk("s1 sys_rst e13", sys_rst, 1'b0);
                  chk("s1 retry e13", retry_count, 0);
                  chk("s1 loss e13", lock_loss_count, 0);

        // Lock glitch during qualification, landing on the final STABLE cycle
        restart(1'b1);
        upto(10); locked = 1'b0;
        upto(13); chk("s3 ready after glitch", ready, 1'b0);
                  locked = 1'b1;
        upto(23); chk("s3 ready e23", ready, 1'b0);
        upto(24); chk("s3 ready e24", ready, 1'b1);
                  chk("s3 retry", retry_count, 0);

        // Lock loss in RUN
        locked = 1'b0;
        upto(26); chk("s4 ready e26", ready, 1'b1);
        upto(27); chk("s4 ready e27", ready, 1'b0);
                  chk("s4 sys_rst e27", sys_rst, 1'b1);
                  chk("s4 loss e27", lock_loss_count, 1);
                  chk("s4 pll_resetb e27", pll_resetb, 1'b0);
                  locked = 1'b1;
        upto(30); chk("s4 pll_resetb e30", pll_resetb, 1'b0);
        upto(31); chk("s4 pll_resetb e31", pll_resetb, 1'b1);
        upto(39); chk("s4 ready e39", ready, 1'b0);
        upto(40); chk("s4 ready e40", ready, 1'b1);

        // Asynchronous reset mid-RUN
        upto(42);
        #2 rst_n = 1'b0;
        #1;
        chk("s6 sys_rst async", sys_rst, 1'b1);
        chk("s6 ready async", ready, 1'b0);
        chk("s6 pll_resetb async", pll_resetb, 1'b0);
        chk("s6 loss async", lock_loss_count, 0);
        chk("s6 retry async", retry_count, 0);

        // Never locks: repeated timeouts, counter saturates
        restart(1'b0);
        upto(35);  chk("s2 pll_resetb e35", pll_resetb, 1'b1);
                   chk("s2 retry e35", retry_count, 0);
        upto(36);  chk("s2 pll_resetb e36", pll_resetb, 1'b0);
                   chk("s2 retry e36", retry_count, 1);
        upto(39);  chk("s2 pll_resetb e39", pll_resetb, 1'b0);
        upto(40);  chk("s2 pll_resetb e40", pll_resetb, 1'b1);
        upto(72);  chk("s2 retry e72", retry_count, 2);
        upto(107); chk("s2 retry e107", retry_count, 2);
        upto(108); chk("s2 retry e108", retry_count, 3);
        upto(143); chk("s2 pll_resetb e143", pll_resetb, 1'b1);
        upto(144); chk("s2 retry e144", retry_count, 3);
                   chk("s2 pll_resetb e144", pll_resetb, 1'b0);
                   chk("s2 sys_rst e144", sys_rst, 1'b1);

        // Clear coinciding with a timeout increment
        restart(1'b0);
        upto(107); chk("s5 retry e107", retry_count, 2);
                   clr_counts = 1'b1;
        upto(108); chk("s5 retry cleared", retry_count, 0);
                   clr_counts = 1'b0;
        upto(110); chk("s5 retry stays 0", retry_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
